// File: rtl/physical_regfile_2w.sv
// Physical register file: 2 write ports, 4 combinational read ports with same-cycle
// write bypass, per-register ready bit, and register 0 hardwired to zero/ready.

module physical_regfile_2w_rdport #(
  parameter int AW = 6,
  parameter int DW = 64
) (
  input  logic [AW-1:0] i_addr,
  input  logic          i_byp1_v,
  input  logic [AW-1:0] i_byp1_addr,
  input  logic [DW-1:0] i_byp1_data,
  input  logic          i_byp2_v,
  input  logic [AW-1:0] i_byp2_addr,
  input  logic [DW-1:0] i_byp2_data,
  input  logic [DW-1:0] i_arr_data,
  input  logic          i_arr_ready,
  output logic [DW-1:0] o_data,
  output logic          o_ready
);
  always_comb begin
    o_data  = i_arr_data;
    o_ready = i_arr_ready;
    if (i_addr == '0) begin
      o_data  = '0;
      o_ready = 1'b1;
    end else if (i_byp1_v && (i_byp1_addr == i_addr)) begin
      o_data  = i_byp1_data;
      o_ready = 1'b1;
    end else if (i_byp2_v && (i_byp2_addr == i_addr)) begin
      o_data  = i_byp2_data;
      o_ready = 1'b1;
    end
  end
endmodule

module physical_regfile_2w #(
  parameter int REG_ADDR_WIDTH = 6,
  parameter int REG_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wr_first_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wr_first_address,
  input  logic [REG_DATA_WIDTH-1:0] wr_first_data,
  input  logic                      wr_second_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wr_second_address,
  input  logic [REG_DATA_WIDTH-1:0] wr_second_data,
  input  logic                      alloc1_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alloc1_address,
  input  logic                      alloc2_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alloc2_address,
  input  logic [REG_ADDR_WIDTH-1:0] rd1_address,
  input  logic [REG_ADDR_WIDTH-1:0] rd2_address,
  input  logic [REG_ADDR_WIDTH-1:0] rd3_address,
  input  logic [REG_ADDR_WIDTH-1:0] rd4_address,
  output logic [REG_DATA_WIDTH-1:0] rd1_data,
  output logic [REG_DATA_WIDTH-1:0] rd2_data,
  output logic [REG_DATA_WIDTH-1:0] rd3_data,
  output logic [REG_DATA_WIDTH-1:0] rd4_data,
  output logic                      rd1_ready,
  output logic                      rd2_ready,
  output logic                      rd3_ready,
  output logic                      rd4_ready
);
  localparam int DEPTH = 1 << REG_ADDR_WIDTH;
  localparam int NUM_RD = 4;

  logic [DEPTH-1:0][REG_DATA_WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]                     r_ready;
  logic [DEPTH-1:0]                     w_ready_nxt;

  logic [NUM_RD-1:0][REG_ADDR_WIDTH-1:0] w_rd_addr;
  logic [NUM_RD-1:0][REG_DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_RD-1:0]                     w_rd_ready;

  // Bypass is suppressed while reset is held so reads show the reset image.
  logic w_byp1_v, w_byp2_v;
  assign w_byp1_v = wr_first_valid  & rstn;
  assign w_byp2_v = wr_second_valid & rstn;

  // Allocates are applied after writes so a same-cycle allocate leaves the bit clear.
  always_comb begin
    w_ready_nxt = r_ready;
    if (wr_first_valid)  w_ready_nxt[wr_first_address]  = 1'b1;
    if (wr_second_valid) w_ready_nxt[wr_second_address] = 1'b1;
    if (alloc1_valid)    w_ready_nxt[alloc1_address]    = 1'b0;
    if (alloc2_valid)    w_ready_nxt[alloc2_address]    = 1'b0;
    w_ready_nxt[0] = 1'b1;
  end

  // Second port is assigned first so the first port wins an address collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem   <= '0;
      r_ready <= '1;
    end else begin
      r_ready <= w_ready_nxt;
      if (wr_second_valid && (wr_second_address != '0))
        r_mem[wr_second_address] <= wr_second_data;
      if (wr_first_valid && (wr_first_address != '0))
        r_mem[wr_first_address] <= wr_first_data;
    end
  end

  assign w_rd_addr = {rd4_address, rd3_address, rd2_address, rd1_address};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    physical_regfile_2w_rdport #(
      .AW(REG_ADDR_WIDTH),
      .DW(REG_DATA_WIDTH)
    ) u_rd (
      .i_addr      (w_rd_addr[p]),
      .i_byp1_v    (w_byp1_v),
      .i_byp1_addr (wr_first_address),
      .i_byp1_data (wr_first_data),
      .i_byp2_v    (w_byp2_v),
      .i_byp2_addr (wr_second_address),
      .i_byp2_data (wr_second_data),
      .i_arr_data  (r_mem[w_rd_addr[p]]),
      .i_arr_ready (r_ready[w_rd_addr[p]]),
      .o_data      (w_rd_data[p]),
      .o_ready     (w_rd_ready[p])
    );
  end

  assign rd1_data  = w_rd_data[0];
  assign rd2_data  = w_rd_data[1];
  assign rd3_data  = w_rd_data[2];
  assign rd4_data  = w_rd_data[3];
  assign rd1_ready = w_rd_ready[0];
  assign rd2_ready = w_rd_ready[1];
  assign rd3_ready = w_rd_ready[2];
  assign rd4_ready = w_rd_ready[3];
endmodule

// File: doc/physical_regfile_2w.md
# physical_regfile_2w

Physical register file with two write ports and four combinational read ports, directly downstream of the writeback selector that reduces six writeback requests to a first and a second write. Stores `2^REG_ADDR_WIDTH` physical registers and keeps one ready (not-busy) bit per register. Write data is bypassed to the read ports in the same cycle. Physical register 0 is hardwired to zero and is always ready. It serves issue-queue operand reads and rename-time readiness checks.

## Interface
- `REG_ADDR_WIDTH`, 6, physical register index width; depth = 2^REG_ADDR_WIDTH
- `REG_DATA_WIDTH`, 64, register data width

- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset; one clock, asynchronous, active-low
- `wr_first_valid` / `wr_second_valid`  in  1  write-port enables
- `wr_first_address` / `wr_second_address`  in  REG_ADDR_WIDTH  write targets
- `wr_first_data` / `wr_second_data`  in  REG_DATA_WIDTH  write data
- `alloc1_valid` / `alloc2_valid`  in  1  rename allocates a destination; clears that register's ready bit
- `alloc1_address` / `alloc2_address`  in  REG_ADDR_WIDTH  allocated register
- `rd1_address` .. `rd4_address`  in  REG_ADDR_WIDTH  read addresses
- `rd1_data` .. `rd4_data`  out  REG_DATA_WIDTH  read data, combinational
- `rd1_ready` .. `rd4_ready`  out  1  operand available, combinational

## Operation
- Storage is an array of `2^REG_ADDR_WIDTH` × `REG_DATA_WIDTH` flops plus a ready vector of `2^REG_ADDR_WIDTH` bits.
- Reset (`rstn`=0, asynchronous) sets every data entry to 0 and every ready bit to 1. While reset is held, all `rdN_data` read 0 and all `rdN_ready` read 1.
- Write: on each rising edge, each valid write port with address ≠ 0 stores its data and sets the register's ready bit.
  - Writes to address 0 are discarded.
  - If both ports are valid to the same nonzero address, `wr_first_data` is stored. The upstream selector never issues this case; the behaviour is still defined.
- Allocate: on each rising edge, each valid alloc port with address ≠ 0 clears that ready bit. Allocation to address 0 is ignored.
  - If an allocate and a write target the same register in the same cycle, the allocate wins and the ready bit ends at 0. The new producer supersedes the old value. The data is still written.
  - `alloc1` and `alloc2` to the same address clear the bit once, with no error.
- Read, combinational, per port N, in priority order:
  1. If `rdN_address` = 0: data 0, ready 1.
  2. Else if `wr_first_valid` and the address matches: `wr_first_data`, ready 1.
  3. Else if `wr_second_valid` and the address matches: `wr_second_data`, ready 1.
  4. Else: array entry and the stored ready bit.
- Same-cycle allocates do not affect the read outputs. Their ready-bit clear becomes visible the following cycle.
- There is no flush input. Recovery of ready bits on mispredict is done by issuing writes to the squashed registers, which sets them ready.

## Timing
- Read latency is 0 cycles: combinational from the address, array, and write ports.
- Write-to-read latency:
  - Bypass makes the value visible in the same cycle.
  - The array holds the value from the next rising edge onward.
- Ready bit:
  - A write sets it visibly on the read port in the same cycle (bypass) and in storage after the edge.
  - An allocate clears it after the edge.
- No handshakes. Every valid write or allocate is accepted every cycle; there is no backpressure.
- If reset is asserted mid-cycle, any pending write or allocate is lost. State returns to reset values immediately. Operation resumes on the first rising edge after `rstn` deasserts.

## Test plan
- **Reset:** assert `rstn`=0, then release. Read addresses 0, 5, 63: data 0 and ready 1 on all four ports.
- **Dual write plus bypass:** `wr_first` writes 0xAAAA to address 3 and `wr_second` writes 0x5555 to address 9 in the same cycle, with `rd1`=3 and `rd2`=9. Both read ports show the new data and ready 1 in the same cycle, and the values persist on the following cycle with the write ports idle.
- **Address 0:** write 0x1234 to address 0, then read address 0. Data stays 0 and ready stays 1. Allocate address 0: ready remains 1.
- **Allocate then write:** allocate address 12.
  - Next cycle: `rd3`=12 shows ready 0.
  - Write 0x77 to address 12: ready 1 and data 0x77 in the same cycle, and still after the edge.
- **Collisions:**
  - Allocate and write address 20 (data 0x99) in the same cycle: after the edge, ready 0 and data 0x99.
  - Both write ports target address 7 with 0x1 and 0x2: after the edge, address 7 holds 0x1.
- **Async reset mid-operation:** write 0xFF to address 4, then pulse `rstn` low between clock edges. Address 4 reads 0 immediately, and all ready bits read 1.
